// File: rtl/spectrum_bin_buffer.sv
`default_nettype none
// ============================================================================
// Module      : spectrum_bin_buffer
// Description : Converts the STFT complex bin stream into saturated unsigned
//               magnitudes and stores them in a double-buffered bin RAM.
//               The display renderer reads the front bank with 1-cycle latency.
//               Banks swap only on frame_sync, so a displayed frame never tears.
//               Optional feature macro: SPECTRUM_PEAK_HOLD_EN (peak-hold bars
//               that fall by DECAY per frame).
// Revision    : 1.0 - initial release
// ============================================================================
module spectrum_bin_buffer #(
   parameter int WORD_WIDTH = 16,
   parameter int FFT_SIZE   = 256,
   parameter int NUM_BINS   = 128,
   parameter int MAG_WIDTH  = 8,
   parameter int MAG_SHIFT  = 8,
   parameter int DECAY      = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        wr_en,
   input  logic [$clog2(FFT_SIZE)-1:0] wr_idx,
   input  logic [2*WORD_WIDTH-1:0]     wr_data,
   input  logic                        frame_sync,
   input  logic [$clog2(NUM_BINS)-1:0] rd_addr,
   output logic [MAG_WIDTH-1:0]        rd_data,
   output logic                        frame_ready,
   output logic                        overrun
);

   localparam int c_addr_w = $clog2(NUM_BINS);
   localparam int c_sum_w  = WORD_WIDTH + 1;
   localparam logic [WORD_WIDTH-1:0] c_abs_max  = {1'b0, {(WORD_WIDTH-1){1'b1}}};
   localparam logic [WORD_WIDTH-1:0] c_most_neg = {1'b1, {(WORD_WIDTH-1){1'b0}}};
   localparam logic [c_sum_w-1:0]    c_mag_lim  = c_sum_w'((1 << MAG_WIDTH) - 1);
   localparam logic [c_addr_w-1:0]   c_last_idx = c_addr_w'(NUM_BINS - 1);

   // Absolute value; the most negative code has no positive twin, so clamp it.
   function automatic logic [WORD_WIDTH-1:0] abs_sat(input logic [WORD_WIDTH-1:0] v);
      if (v == c_most_neg)
         abs_sat = c_abs_max;
      else if (v[WORD_WIDTH-1])
         abs_sat = -v;
      else
         abs_sat = v;
   endfunction

   // Bank RAM: upper address bit selects the bank.
   logic [MAG_WIDTH-1:0]  r_mem [0:2*NUM_BINS-1];

   logic                  r_s1_valid, r_s2_valid, r_s3_valid;
   logic [c_addr_w-1:0]   r_s1_idx, r_s2_idx, r_s3_idx;
   logic [WORD_WIDTH-1:0] r_s1_abs_re, r_s1_abs_im;
   logic [MAG_WIDTH-1:0]  r_s2_mag, r_s3_mag;
   logic                  r_bank_sel, r_pending;

   logic                  w_in_range;
   logic [WORD_WIDTH-1:0] w_max, w_min;
   logic [c_sum_w-1:0]    w_sum, w_shifted;
   logic [MAG_WIDTH-1:0]  w_mag, w_s3_val;
   logic                  w_busy, w_swap, w_complete, w_front_next;

   assign w_in_range   = wr_en && (32'(wr_idx) < NUM_BINS);
   assign w_max        = (r_s1_abs_re > r_s1_abs_im) ? r_s1_abs_re : r_s1_abs_im;
   assign w_min        = (r_s1_abs_re > r_s1_abs_im) ? r_s1_abs_im : r_s1_abs_re;
   assign w_sum        = {1'b0, w_max} + {1'b0, (w_min >> 1)};
   assign w_shifted    = w_sum >> MAG_SHIFT;
   assign w_mag        = (w_shifted > c_mag_lim) ? {MAG_WIDTH{1'b1}} : w_shifted[MAG_WIDTH-1:0];
   assign w_busy       = r_s1_valid | r_s2_valid | r_s3_valid;
   assign w_swap       = frame_sync & r_pending & ~w_busy;
   assign w_complete   = r_s3_valid && (r_s3_idx == c_last_idx);
   assign w_front_next = r_bank_sel ^ w_swap;

`ifdef SPECTRUM_PEAK_HOLD_EN
   logic [MAG_WIDTH-1:0] r_s1_front, r_s2_front;
   logic [MAG_WIDTH-1:0] w_decayed;

   // Second read port: current front value of the incoming bin (post-swap bank).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1_front <= '0;
         r_s2_front <= '0;
      end else begin
         r_s1_front <= r_mem[{w_front_next, wr_idx[c_addr_w-1:0]}];
         r_s2_front <= r_s1_front;
      end
   end

   assign w_decayed = (r_s2_front > MAG_WIDTH'(DECAY)) ? (r_s2_front - MAG_WIDTH'(DECAY)) : '0;
   assign w_s3_val  = (r_s2_mag > w_decayed) ? r_s2_mag : w_decayed;
`else
   logic w_decay_unused;
   assign w_decay_unused = (DECAY != 0) ^ w_front_next;
   assign w_s3_val       = r_s2_mag;
`endif

   // Three-stage magnitude pipeline; out-of-range bins never enter it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1_valid  <= 1'b0;
         r_s2_valid  <= 1'b0;
         r_s3_valid  <= 1'b0;
         r_s1_idx    <= '0;
         r_s2_idx    <= '0;
         r_s3_idx    <= '0;
         r_s1_abs_re <= '0;
         r_s1_abs_im <= '0;
         r_s2_mag    <= '0;
         r_s3_mag    <= '0;
      end else begin
         r_s1_valid  <= w_in_range;
         r_s1_idx    <= wr_idx[c_addr_w-1:0];
         r_s1_abs_re <= abs_sat(wr_data[2*WORD_WIDTH-1:WORD_WIDTH]);
         r_s1_abs_im <= abs_sat(wr_data[WORD_WIDTH-1:0]);
         r_s2_valid  <= r_s1_valid;
         r_s2_idx    <= r_s1_idx;
         r_s2_mag    <= w_mag;
         r_s3_valid  <= r_s2_valid;
         r_s3_idx    <= r_s2_idx;
         r_s3_mag    <= w_s3_val;
      end
   end

   // Back-bank write from the last stage.
   always_ff @(posedge clk) begin
      if (r_s3_valid)
         r_mem[{~r_bank_sel, r_s3_idx}] <= r_s3_mag;
   end

   // Bank control: completion arms a swap that is taken on an idle frame_sync.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_bank_sel  <= 1'b0;
         r_pending   <= 1'b0;
         frame_ready <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         overrun <= w_complete & r_pending;
         if (w_swap) begin
            r_bank_sel  <= ~r_bank_sel;
            r_pending   <= 1'b0;
            frame_ready <= 1'b1;
         end else if (w_complete) begin
            r_pending <= 1'b1;
         end
      end
   end

   // Display read port on the front bank.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         rd_data <= '0;
      else
         rd_data <= r_mem[{r_bank_sel, rd_addr}];
   end

endmodule
`default_nettype wire

// File: tb/tb_spectrum_bin_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_spectrum_bin_buffer
// Description : Self-checking bench for spectrum_bin_buffer. Two instances
//               (MAG_SHIFT 8 and 6) share one stimulus stream; a bank-level
//               reference model tracks both banks and the swap rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spectrum_bin_buffer;
   localparam int NB = 128;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       wr_en = 1'b0;
   logic       frame_sync = 1'b0;
   logic [7:0] wr_idx = '0;
   logic [31:0] wr_data = '0;
   logic [6:0] rd_addr = '0;
   logic [7:0] rd_data_a, rd_data_b;
   logic       ready_a, ready_b, ovr_a, ovr_b;

   int checks = 0;
   int errors = 0;
   int mem_a [2][NB];
   int mem_b [2][NB];
   int sel = 0, pending = 0, ready = 0;
   int exp_ovr = 0, ovr_cnt_a = 0, ovr_cnt_b = 0;
   int cyc = 0, last_wr_cyc = -100;

   always #5 clk = ~clk;

   spectrum_bin_buffer u_dut_a (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
      .frame_sync(frame_sync), .rd_addr(rd_addr), .rd_data(rd_data_a),
      .frame_ready(ready_a), .overrun(ovr_a));

   spectrum_bin_buffer #(.MAG_SHIFT(6)) u_dut_b (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
      .frame_sync(frame_sync), .rd_addr(rd_addr), .rd_data(rd_data_b),
      .frame_ready(ready_b), .overrun(ovr_b));

   // Count overrun pulses, sampled away from the active edge.
   always @(negedge clk) begin
      if (ovr_a) ovr_cnt_a++;
      if (ovr_b) ovr_cnt_b++;
   end

   function automatic int mag_of(input int re, input int im, input int sh);
      int ar, ai, mx, mn, m;
      ar = (re < 0) ? -re : re;
      ai = (im < 0) ? -im : im;
      if (ar > 32767) ar = 32767;
      if (ai > 32767) ai = 32767;
      mx = (ar > ai) ? ar : ai;
      mn = (ar > ai) ? ai : ar;
      m  = (mx + mn / 2) / (1 << sh);
      if (m > 255) m = 255;
      return m;
   endfunction

   function automatic int rnd_word();
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      assert (act === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic write_bin(input int idx, input int re, input int im);
      int ma, mb;
      wr_en   = 1'b1;
      wr_idx  = idx[7:0];
      wr_data = {re[15:0], im[15:0]};
      if (idx < NB) begin
         ma = mag_of(re, im, 8);
         mb = mag_of(re, im, 6);
`ifdef SPECTRUM_PEAK_HOLD_EN
         if (mem_a[sel][idx] - 2 > ma) ma = mem_a[sel][idx] - 2;
         if (mem_b[sel][idx] - 2 > mb) mb = mem_b[sel][idx] - 2;
`endif
         mem_a[1-sel][idx] = ma;
         mem_b[1-sel][idx] = mb;
         last_wr_cyc = cyc;
         if (idx == NB - 1) begin
            if (pending != 0) exp_ovr++;
            else pending = 1;
         end
      end
      tick();
      wr_en = 1'b0;
   endtask

   task automatic sync_pulse();
      int busy;
      busy = (cyc >= last_wr_cyc + 1 && cyc <= last_wr_cyc + 3) ? 1 : 0;
      frame_sync = 1'b1;
      if (pending != 0 && busy == 0) begin
         sel = 1 - sel;
         pending = 0;
         ready = 1;
      end
      tick();
      frame_sync = 1'b0;
   endtask

   task automatic check_read(input int addr, input string tag);
      rd_addr = addr[6:0];
      tick();
      if (mem_a[sel][addr] >= 0) chk({tag, "_a"}, {24'd0, rd_data_a}, mem_a[sel][addr]);
      if (mem_b[sel][addr] >= 0) chk({tag, "_b"}, {24'd0, rd_data_b}, mem_b[sel][addr]);
   endtask

   task automatic check_reads(input int n, input string tag);
      for (int k = 0; k < n; k++) check_read(int'($urandom_range(0, NB - 1)), tag);
   endtask

   task automatic check_status(input string tag);
      chk({tag, "_ready_a"}, {31'd0, ready_a}, ready);
      chk({tag, "_ready_b"}, {31'd0, ready_b}, ready);
   endtask

   // Full frame in index order with random data, junk indices and overwrites.
   task automatic write_frame(input int sp_idx, input int sp_re, input int sp_im);
      for (int i = 0; i < NB; i++) begin
         if ($urandom_range(0, 7) == 0) write_bin(128 + int'($urandom_range(0, 127)), rnd_word(), rnd_word());
         if (i > 0 && $urandom_range(0, 15) == 0) write_bin(int'($urandom_range(0, i - 1)), rnd_word(), rnd_word());
         if (i == sp_idx) write_bin(i, sp_re, sp_im);
         else write_bin(i, rnd_word(), rnd_word());
      end
   endtask

   initial begin
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < NB; i++) begin
            mem_a[b][i] = -1;
            mem_b[b][i] = -1;
         end

      // Reset state
      idle(3);
      chk("rst_rd_a", {24'd0, rd_data_a}, 0);
      chk("rst_rd_b", {24'd0, rd_data_b}, 0);
      chk("rst_ovr", {31'd0, ovr_a}, 0);
      check_status("rst");
      reset = 1'b1;
      tick();

      // Known bin 5 = (3000,-4000)
      write_frame(5, 3000, -4000);
      idle(4);
      sync_pulse();
      check_status("t1");
      check_read(5, "t1_bin5");
      chk("t1_bin5_const", {24'd0, rd_data_a}, 21);
      check_reads(6, "t1");

      // Most negative inputs: 191 at shift 8, saturated 255 at shift 6
      write_frame(7, -32768, -32768);
      idle(4);
      sync_pulse();
      check_read(7, "t2_bin7");
      chk("t2_sat_a", {24'd0, rd_data_a}, 191);
      chk("t2_sat_b", {24'd0, rd_data_b}, 255);

      // Out-of-range index 255 must not complete a frame
      write_bin(255, 1000, 1000);
      idle(4);
      sync_pulse();
      check_read(127, "t3_nocomplete");
      // Out-of-range index 200 must not touch bin 72 of the back bank
      write_bin(200, 20000, 20000);
      write_bin(10, rnd_word(), rnd_word());
      write_bin(127, rnd_word(), rnd_word());
      idle(4);
      sync_pulse();
      check_read(72, "t3_bin72");
      check_read(10, "t3_bin10");
      check_read(127, "t3_bin127");

      // Two frames without frame_sync -> one overrun, newest frame shown
      write_frame(-1, 0, 0);
      write_frame(-1, 0, 0);
      idle(4);
      chk("t4_ovr_a", ovr_cnt_a, exp_ovr);
      chk("t4_ovr_b", ovr_cnt_b, exp_ovr);
      sync_pulse();
      check_reads(6, "t4");

      // frame_sync coincident with the completing write: held, next sync swaps
      write_bin(3, rnd_word(), rnd_word());
      write_bin(127, rnd_word(), rnd_word());
      idle(2);
      sync_pulse();
      check_read(127, "t5_held");
      check_read(3, "t5_held3");
      idle(2);
      sync_pulse();
      check_read(127, "t5_swapped");
      check_read(3, "t5_swapped3");

      // Asynchronous reset mid-frame discards the partial back frame
      for (int i = 0; i < 20; i++) write_bin(i, rnd_word(), rnd_word());
      write_bin(127, rnd_word(), rnd_word());
      idle(1);
      reset = 1'b0;
      #1;
      chk("mid_rst_rd_a", {24'd0, rd_data_a}, 0);
      chk("mid_rst_ovr", {31'd0, ovr_a}, 0);
      chk("mid_rst_ready", {31'd0, ready_a}, 0);
      // Bins still in flight at reset never land in the RAM
      mem_a[1-sel][127] = -1;
      mem_b[1-sel][127] = -1;
      sel = 0; pending = 0; ready = 0; last_wr_cyc = -100;
      tick();
      reset = 1'b1;
      tick();
      sync_pulse();
      check_status("post_rst");
      check_reads(4, "post_rst");

      // Random frames with random frame_sync timing
      for (int f = 0; f < 4; f++) begin
         write_frame(-1, 0, 0);
         idle(int'($urandom_range(0, 5)));
         sync_pulse();
         check_read(127, "rnd_a");
         idle(4);
         sync_pulse();
         check_status("rnd");
         check_reads(4, "rnd_b");
      end
      chk("end_ovr_a", ovr_cnt_a, exp_ovr);
      chk("end_ovr_b", ovr_cnt_b, exp_ovr);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
